rect_fill_engine: RTL and testbench
===================================

// Module: rect_fill_engine
// PURPOSE
//  Parametrised rectangle fill engine; generalises the fixed 16x16 black card-clear.
//  - Latches origin, per-request width/height and fill colour on a start pulse.
//  - Streams one pixel per clock (x, y, colour, plot) to the VGA adapter.
//  - Ends with a one-cycle done pulse.
//  - Sits between the game control FSM and the vga_adapter plot port.
//  - Serves card draw, card clear and background wipes.
// PARAMETERS
//  X_W       8    x coordinate width
//  Y_W       7    y coordinate width
//  COL_W     3    colour width
//  DIM_W     4    width/height field width; max rectangle 2^DIM_W per side
//  SCREEN_W  160  pixels with x >= SCREEN_W are clipped
//  SCREEN_H  120  pixels with y >= SCREEN_H are clipped
// PORTS
//  clk       in   1      system clock, all logic on rising edge
//  reset_n   in   1      Reset is asynchronous and active-low; one clock, clk.
//  start     in   1      request pulse; sampled only in IDLE
//  x0        in   X_W    top-left x
//  y0        in   Y_W    top-left y
//  w_m1      in   DIM_W  width minus 1
//  h_m1      in   DIM_W  height minus 1
//  colour    in   COL_W  fill colour
//  x         out  X_W    pixel x (registered)
//  y         out  Y_W    pixel y (registered)
//  colour_o  out  COL_W  pixel colour (registered)
//  plot      out  1      pixel valid / write enable to VGA
//  busy      out  1      high from cycle after start until done inclusive
//  done      out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; x, y, colour_o, plot, busy, done and internal counters cx, cy all 0.
//   Reset mid-operation aborts immediately; no done pulse is generated.
//  FSM states: IDLE, DRAW, FIN.
//   IDLE: start=1 latches x0, y0, w_m1, h_m1, colour (and border colour when enabled);
//    clears cx and cy; goes to DRAW.
//   DRAW: each cycle presents pixel (x0+cx, y0+cy).
//    Scan is raster order: cx increments; at cx==w_m1, cx wraps to 0 and cy increments.
//    Pixel (w_m1, h_m1) is the last; the FSM then goes to FIN.
//   FIN: done=1 for exactly one cycle; FSM returns to IDLE.
//  Timing, with start sampled at edge 0:
//   - First pixel registered on the outputs after edge 1.
//   - Exactly N = (w_m1+1)*(h_m1+1) DRAW cycles.
//   - done is high in the cycle after the last pixel.
//   - A back-to-back start is accepted in the cycle following done.
//  start while busy: ignored; the latched request is unaffected.
//  Live inputs x0, y0, w_m1, h_m1 and colour may change freely after the start cycle.
//  Arithmetic: x = x0 + zero-extended cx, computed at X_W+1 bits; likewise y at Y_W+1.
//  Clipping:
//   - If the unclipped sum >= SCREEN_W (or >= SCREEN_H), plot=0 for that cycle.
//   - The cycle is still consumed, so latency is independent of position.
//   - The x/y outputs carry the truncated sum.
//  Degenerate 1x1 (w_m1=h_m1=0): one DRAW cycle, then FIN.
//  Outside DRAW: plot=0; x, y and colour_o hold their last values.
// CONFIGURATION
//  RECT_FILL_BORDER_EN defined:
//   - Adds input border_colour [COL_W-1:0], latched with colour on start.
//   - Edge pixels (cx==0 | cx==w_m1 | cy==0 | cy==h_m1) output border_colour.
//   - Interior pixels output colour.
//  RECT_FILL_BORDER_EN undefined:
//   - The border_colour port does not exist.
//   - Every pixel outputs colour.
//   - Timing is identical in both builds.
// TESTING
//  1. x0=10,y0=20,w_m1=15,h_m1=15,colour=0 -> 256 plots, first (10,20), last (25,35); done at cycle 257.
//  2. w_m1=0,h_m1=0,x0=5,y0=5,colour=3'b111 -> one plot (5,5,7); done next cycle; busy high 2 cycles.
//  3. x0=155,y0=0,w_m1=7,h_m1=0 -> 8 DRAW cycles; plot=1 for x=155..159, plot=0 for x=160..162.
//  4. Second start at DRAW cycle 3 with different x0 -> ignored; pixels continue from the original origin.
//  5. reset_n low at DRAW cycle 4 -> all outputs 0 asynchronously; IDLE; no done; new start works.
//  6. RECT_FILL_BORDER_EN, 4x3, colour=1, border=4 -> interior (1,1),(2,1) colour 1; other 10 pixels colour 4.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: streams one pixel per clock for a latched rectangle.
// Optional build macro RECT_FILL_BORDER_EN adds a separate border colour.
module rect_fill_engine #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int COL_W    = 3,
   parameter int DIM_W    = 4,
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [X_W-1:0]   x0,
   input  logic [Y_W-1:0]   y0,
   input  logic [DIM_W-1:0] w_m1,
   input  logic [DIM_W-1:0] h_m1,
   input  logic [COL_W-1:0] colour,
`ifdef RECT_FILL_BORDER_EN
   input  logic [COL_W-1:0] border_colour,
`endif
   output logic [X_W-1:0]   x,
   output logic [Y_W-1:0]   y,
   output logic [COL_W-1:0] colour_o,
   output logic             plot,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

   localparam logic [X_W:0] SW = (X_W+1)'(SCREEN_W);
   localparam logic [Y_W:0] SH = (Y_W+1)'(SCREEN_H);

   state_t state, state_d;

   logic [X_W-1:0]   x0_l;
   logic [Y_W-1:0]   y0_l;
   logic [DIM_W-1:0] w_l;
   logic [DIM_W-1:0] h_l;
   logic [COL_W-1:0] col_l;
   logic [DIM_W-1:0] cx;
   logic [DIM_W-1:0] cy;

   logic             accept;
   logic             last;
   logic             row_end;
   logic [X_W:0]     xs;
   logic [Y_W:0]     ys;
   logic             on_screen;
   logic [COL_W-1:0] pix_col;

`ifdef RECT_FILL_BORDER_EN
   logic [COL_W-1:0] bcol_l;
   logic             is_edge;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // Next-state logic; the done cycle is still busy, so start waits one more cycle
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (start && !done) state_d = DRAW;
         DRAW:    if (last)           state_d = FIN;
         FIN:                         state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Pixel address, clip test and colour select for the current scan position
   always_comb begin
      accept    = (state == IDLE) && start && !done;
      row_end   = (cx == w_l);
      last      = row_end && (cy == h_l);
      xs        = {1'b0, x0_l} + {{(X_W+1-DIM_W){1'b0}}, cx};
      ys        = {1'b0, y0_l} + {{(Y_W+1-DIM_W){1'b0}}, cy};
      on_screen = (xs < SW) && (ys < SH);
`ifdef RECT_FILL_BORDER_EN
      is_edge   = (cx == '0) || row_end || (cy == '0) || (cy == h_l);
      pix_col   = is_edge ? bcol_l : col_l;
`else
      pix_col   = col_l;
`endif
   end

   // Request latch, scan counters and registered pixel outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x0_l     <= '0;
         y0_l     <= '0;
         w_l      <= '0;
         h_l      <= '0;
         col_l    <= '0;
         cx       <= '0;
         cy       <= '0;
         x        <= '0;
         y        <= '0;
         colour_o <= '0;
         plot     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         plot <= (state == DRAW) && on_screen;
         busy <= (state == DRAW) || (state == FIN);
         done <= (state == FIN);
         if (accept) begin
            x0_l  <= x0;
            y0_l  <= y0;
            w_l   <= w_m1;
            h_l   <= h_m1;
            col_l <= colour;
            cx    <= '0;
            cy    <= '0;
         end
         if (state == DRAW) begin
            x        <= xs[X_W-1:0];
            y        <= ys[Y_W-1:0];
            colour_o <= pix_col;
            if (row_end) begin
               cx <= '0;
               cy <= cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end
      end
   end

`ifdef RECT_FILL_BORDER_EN
   // Border colour is latched alongside the fill colour
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    bcol_l <= '0;
      else if (accept) bcol_l <= border_colour;
   end
`endif

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine.
// Pixels are checked against a raster model of the latched request.
module tb_rect_fill_engine;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [7:0] x0;
   logic [6:0] y0;
   logic [3:0] w_m1;
   logic [3:0] h_m1;
   logic [2:0] colour;
   logic [2:0] border_colour;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour_o;
   logic       plot;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;
   int np;

   rect_fill_engine dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .x0            (x0),
      .y0            (y0),
      .w_m1          (w_m1),
      .h_m1          (h_m1),
      .colour        (colour),
`ifdef RECT_FILL_BORDER_EN
      .border_colour (border_colour),
`endif
      .x             (x),
      .y             (y),
      .colour_o      (colour_o),
      .plot          (plot),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   // Drive a request at a negedge; returns at the first pixel's sample point.
   // Live inputs are scrambled right after the start cycle.
   task automatic issue(input int ax, input int ay, input int aw,
                        input int ah, input int ac, input int ab);
      x0 = 8'(ax); y0 = 7'(ay); w_m1 = 4'(aw); h_m1 = 4'(ah);
      colour = 3'(ac); border_colour = 3'(ab);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x0 = 8'hAA; y0 = 7'h55; w_m1 = 4'hE; h_m1 = 4'hE;
      colour = ~3'(ac); border_colour = ~3'(ab);
      chk("pre_plot", 32'(plot), 32'd0);
      @(negedge clk);
   endtask

   task automatic draw_check(input int ax, input int ay, input int aw,
                             input int ah, input int ac, input int ab,
                             input int intrude, output int nplot);
      int i, ex, ey, ec, ep;
      issue(ax, ay, aw, ah, ac, ab);
      nplot = 0;
      i = 0;
      ex = 0;
      ey = 0;
      for (int cy = 0; cy <= ah; cy++) begin
         for (int cx = 0; cx <= aw; cx++) begin
            ex = ax + cx;
            ey = ay + cy;
            ep = (ex < 160 && ey < 120) ? 1 : 0;
            ec = ac;
`ifdef RECT_FILL_BORDER_EN
            if (cx == 0 || cx == aw || cy == 0 || cy == ah) ec = ab;
`endif
            chk("pix", {13'd0, plot, x, y, colour_o},
                {13'd0, 1'(ep), 8'(ex), 7'(ey), 3'(ec)});
            chk("busy_draw", {30'd0, busy, done}, 32'd2);
            if (plot) nplot++;
            start = (i == intrude);
            if (i == intrude) x0 = 8'd3;
            i++;
            @(negedge clk);
         end
      end
      start = 1'b0;
      chk("done_hi", {29'd0, done, plot, busy}, 32'd5);
      chk("hold_xy", {17'd0, x, y}, {17'd0, 8'(ex), 7'(ey)});
      @(negedge clk);
      chk("done_lo", {30'd0, done, busy}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      x0 = '0; y0 = '0; w_m1 = '0; h_m1 = '0;
      colour = '0; border_colour = '0;
      repeat (2) @(negedge clk);
      chk("rst_out", {11'd0, x, y, colour_o, plot, busy, done}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      draw_check(10, 20, 15, 15, 0, 0, -1, np);
      chk("t1_plots", np, 256);

      draw_check(5, 5, 0, 0, 7, 7, -1, np);
      chk("t2_plots", np, 1);

      draw_check(155, 0, 7, 0, 2, 2, -1, np);
      chk("t3_plots", np, 5);

      draw_check(40, 30, 3, 2, 5, 5, 2, np);
      chk("t4_plots", np, 12);

      issue(60, 60, 7, 7, 6, 6);
      repeat (3) @(negedge clk);
      chk("t5_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1 chk("t5_async", {11'd0, x, y, colour_o, plot, busy, done}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("t5_quiet", {29'd0, done, plot, busy}, 32'd0);
      end
      draw_check(3, 4, 1, 1, 2, 2, -1, np);
      chk("t5_plots", np, 4);

`ifdef RECT_FILL_BORDER_EN
      draw_check(0, 0, 3, 2, 1, 4, -1, np);
      chk("t6_plots", np, 12);
`endif

      draw_check(0, 118, 1, 3, 3, 3, -1, np);
      chk("ybot_plots", np, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
